expansion_xor_pipe: RTL and testbench

//  Parametrised, pipelined bit-select expansion fused with round-key XOR: out = SEL(in) ^ key.

---
 rtl/expansion_xor_pipe_pkg.sv | 29 ++
 rtl/expansion_xor_pipe_if.sv | 27 ++
 rtl/expansion_xor_pipe_bit_select_net.sv | 23 ++
 rtl/expansion_xor_pipe.sv | 111 +++++++++++
 tb/tb_expansion_xor_pipe.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/expansion_xor_pipe_pkg.sv
// Shared constants for the DES round-function datapath: widths and select tables.
// Table entries are 1-based source bit numbers, entry 1 in the most significant slot.
package expansion_xor_pipe_pkg;

    localparam int unsigned DES_HALF_W = 32;
    localparam int unsigned DES_EXP_W  = 48;
    localparam int unsigned DES_IDX_W  = 6;

    // E expansion: 32 -> 48
    localparam logic [DES_EXP_W*DES_IDX_W-1:0] DES_E_TABLE = {
        6'd32, 6'd1,  6'd2,  6'd3,  6'd4,  6'd5,
        6'd4,  6'd5,  6'd6,  6'd7,  6'd8,  6'd9,
        6'd8,  6'd9,  6'd10, 6'd11, 6'd12, 6'd13,
        6'd12, 6'd13, 6'd14, 6'd15, 6'd16, 6'd17,
        6'd16, 6'd17, 6'd18, 6'd19, 6'd20, 6'd21,
        6'd20, 6'd21, 6'd22, 6'd23, 6'd24, 6'd25,
        6'd24, 6'd25, 6'd26, 6'd27, 6'd28, 6'd29,
        6'd28, 6'd29, 6'd30, 6'd31, 6'd32, 6'd1
    };

    // P permutation applied after the S-boxes: 32 -> 32
    localparam logic [DES_HALF_W*DES_IDX_W-1:0] DES_P_TABLE = {
        6'd16, 6'd7,  6'd20, 6'd21, 6'd29, 6'd12, 6'd28, 6'd17,
        6'd1,  6'd15, 6'd23, 6'd26, 6'd5,  6'd18, 6'd31, 6'd10,
        6'd2,  6'd8,  6'd24, 6'd14, 6'd32, 6'd27, 6'd3,  6'd9,
        6'd19, 6'd13, 6'd30, 6'd6,  6'd22, 6'd11, 6'd4,  6'd25
    };

endpackage

// File: rtl/expansion_xor_pipe_if.sv
// Valid/ready stream bundle for the expansion/XOR stage, plus its synchronous flush.
interface expansion_xor_pipe_if
    import expansion_xor_pipe_pkg::*;
#(
    parameter int unsigned IN_W  = DES_HALF_W,
    parameter int unsigned OUT_W = DES_EXP_W
);
    logic             flush;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic [OUT_W-1:0] in_key;
    logic             in_xor_en;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;

    modport master (
        output flush, in_valid, in_data, in_key, in_xor_en, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  flush, in_valid, in_data, in_key, in_xor_en, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/expansion_xor_pipe_bit_select_net.sv
// Pure wiring: output bit j takes the input bit named by table entry j (bit 1 = MSB).
// Entries of 0 or beyond IN_W tie the output bit low.
module bit_select_net #(
    parameter int unsigned IN_W  = 32,
    parameter int unsigned OUT_W = 48,
    parameter int unsigned IDX_W = 6,
    parameter logic [OUT_W*IDX_W-1:0] SEL_TABLE = '0
) (
    input  logic [IN_W-1:0]  in_data,
    output logic [OUT_W-1:0] out_data
);

    // 0-based output bit j is 1-based entry OUT_W-j, stored at slice j*IDX_W
    for (genvar j = 0; j < OUT_W; j++) begin : g_bit
        localparam int unsigned SRC = 32'(SEL_TABLE[j*IDX_W +: IDX_W]);
        if (SRC == 0 || SRC > IN_W) begin : g_zero
            assign out_data[j] = 1'b0;
        end else begin : g_pick
            assign out_data[j] = in_data[IN_W-SRC];
        end
    end

endmodule

// File: rtl/expansion_xor_pipe.sv
// Pipelined bit-select expansion fused with round-key XOR: out = SEL(in) ^ key.
// Defaults give DES E(R) ^ K(i); STAGES picks a 1- or 2-register valid/ready chain.
module expansion_xor_pipe
    import expansion_xor_pipe_pkg::*;
#(
    parameter int unsigned IN_W   = DES_HALF_W,
    parameter int unsigned OUT_W  = DES_EXP_W,
    parameter int unsigned IDX_W  = DES_IDX_W,
    parameter logic [OUT_W*IDX_W-1:0] SEL_TABLE = DES_E_TABLE,
    parameter int unsigned STAGES = 2
) (
    input logic clk,
    input logic rst_n,
    expansion_xor_pipe_if.slave bus
);

    logic             alive_q;
    logic             in_ready_c;
    logic             out_valid_q;
    logic [OUT_W-1:0] out_data_q;
    logic [OUT_W-1:0] sel_c;

    bit_select_net #(
        .IN_W      (IN_W),
        .OUT_W     (OUT_W),
        .IDX_W     (IDX_W),
        .SEL_TABLE (SEL_TABLE)
    ) u_sel (
        .in_data  (bus.in_data),
        .out_data (sel_c)
    );

    // Holds in_ready low through reset and until the first edge after release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) alive_q <= 1'b0;
        else        alive_q <= 1'b1;
    end

    if (STAGES == 2) begin : g_two
        logic             v1_q;
        logic             xe1_q;
        logic [OUT_W-1:0] sel1_q;
        logic [OUT_W-1:0] key1_q;
        logic             adv1_c;
        logic             adv2_c;
        logic             load_c;

        assign adv2_c     = out_valid_q & bus.out_ready;
        assign adv1_c     = v1_q & (~out_valid_q | adv2_c);
        assign in_ready_c = alive_q & ~bus.flush & (~v1_q | adv1_c);
        assign load_c     = bus.in_valid & in_ready_c;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                v1_q        <= 1'b0;
                xe1_q       <= 1'b0;
                sel1_q      <= '0;
                key1_q      <= '0;
                out_valid_q <= 1'b0;
                out_data_q  <= '0;
            end else if (bus.flush) begin
                v1_q        <= 1'b0;
                out_valid_q <= 1'b0;
            end else begin
                if (load_c) begin
                    sel1_q <= sel_c;
                    key1_q <= bus.in_key;
                    xe1_q  <= bus.in_xor_en;
                    v1_q   <= 1'b1;
                end else if (adv1_c) begin
                    v1_q   <= 1'b0;
                end

                if (adv1_c) begin
                    out_data_q  <= sel1_q ^ ({OUT_W{xe1_q}} & key1_q);
                    out_valid_q <= 1'b1;
                end else if (adv2_c) begin
                    out_valid_q <= 1'b0;
                end
            end
        end
    end else if (STAGES == 1) begin : g_one
        logic adv_c;
        logic load_c;

        assign adv_c      = out_valid_q & bus.out_ready;
        assign in_ready_c = alive_q & ~bus.flush & (~out_valid_q | adv_c);
        assign load_c     = bus.in_valid & in_ready_c;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_valid_q <= 1'b0;
                out_data_q  <= '0;
            end else if (bus.flush) begin
                out_valid_q <= 1'b0;
            end else if (load_c) begin
                out_data_q  <= sel_c ^ ({OUT_W{bus.in_xor_en}} & bus.in_key);
                out_valid_q <= 1'b1;
            end else if (adv_c) begin
                out_valid_q <= 1'b0;
            end
        end
    end else begin : g_bad_stages
        $error("expansion_xor_pipe: STAGES must be 1 or 2");
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_expansion_xor_pipe.sv
// Scoreboard bench for expansion_xor_pipe: directed DES E^K vectors on a 2-stage
// instance, plus a 1-stage instance, then a random valid/ready soak on both.
module tb_expansion_xor_pipe;

    localparam int unsigned N_RND = 2000;
    localparam int E_TAB [48] = '{
        32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1
    };

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_fail;
    int   acc2;
    bit   rnd_done;
    logic [47:0] q2[$];
    logic [47:0] q1[$];

    expansion_xor_pipe_if #(.IN_W(32), .OUT_W(48)) b2();
    expansion_xor_pipe_if #(.IN_W(32), .OUT_W(48)) b1();

    expansion_xor_pipe #(.STAGES(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));
    expansion_xor_pipe #(.STAGES(1)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [47:0] ref_exp(input logic [31:0] d, input logic [47:0] k, input logic xe);
        logic [47:0] r;
        for (int j = 0; j < 48; j++) r[47-j] = d[32-E_TAB[j]];
        return xe ? (r ^ k) : r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Offers one beat on the 2-stage DUT; call at posedge+1, returns at posedge+1 after acceptance
    task automatic send2(input logic [31:0] d, input logic [47:0] k, input logic xe, input logic [47:0] exp);
        bit ok;
        ok = 1'b0;
        b2.in_valid = 1'b1; b2.in_data = d; b2.in_key = k; b2.in_xor_en = xe;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (b2.in_ready) begin
                q2.push_back(exp);
                acc2++;
                ok = 1'b1;
            end
            @(posedge clk); #1;
        end
        if (!ok) begin
            n_chk++; n_fail++;
            $display("FAIL send2_timeout: in_ready never rose for data %h", d);
        end
    endtask

    task automatic mon2();
        logic        hold;
        logic [47:0] hd;
        hold = 1'b0; hd = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    chk("s2_hold_valid", 64'(b2.out_valid), 64'd1);
                    chk("s2_hold_data", 64'(b2.out_data), 64'(hd));
                end
                if (b2.out_valid && b2.out_ready && !b2.flush) begin
                    if (q2.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL s2_unexpected_beat: got %h, expected no beat", b2.out_data);
                    end else begin
                        chk("s2_data", 64'(b2.out_data), 64'(q2.pop_front()));
                    end
                end
                hold = b2.out_valid && !b2.out_ready && !b2.flush;
                hd   = b2.out_data;
            end
        end
    endtask

    task automatic mon1();
        logic        hold;
        logic [47:0] hd;
        hold = 1'b0; hd = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold = 1'b0;
            end else begin
                if (hold) begin
                    chk("s1_hold_valid", 64'(b1.out_valid), 64'd1);
                    chk("s1_hold_data", 64'(b1.out_data), 64'(hd));
                end
                if (b1.out_valid && b1.out_ready && !b1.flush) begin
                    if (q1.size() == 0) begin
                        n_chk++; n_fail++;
                        $display("FAIL s1_unexpected_beat: got %h, expected no beat", b1.out_data);
                    end else begin
                        chk("s1_data", 64'(b1.out_data), 64'(q1.pop_front()));
                    end
                end
                hold = b1.out_valid && !b1.out_ready && !b1.flush;
                hd   = b1.out_data;
            end
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 300; i++) begin
            if (q2.size() == 0 && q1.size() == 0) break;
            @(posedge clk);
        end
        chk(name, 64'(q2.size() + q1.size()), 64'd0);
        @(posedge clk); #1;
    endtask

    task automatic rnd2();
        int sent;
        sent = 0;
        while (sent < N_RND) begin
            @(posedge clk); #1;
            b2.in_valid  = ($urandom_range(0, 3) != 0);
            b2.in_data   = $urandom;
            b2.in_key    = 48'({$urandom, $urandom});
            b2.in_xor_en = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (b2.in_valid && b2.in_ready) begin
                q2.push_back(ref_exp(b2.in_data, b2.in_key, b2.in_xor_en));
                sent++;
            end
        end
        @(posedge clk); #1;
        b2.in_valid = 1'b0;
    endtask

    task automatic rnd1();
        int sent;
        sent = 0;
        while (sent < N_RND) begin
            @(posedge clk); #1;
            b1.in_valid  = ($urandom_range(0, 3) != 0);
            b1.in_data   = $urandom;
            b1.in_key    = 48'({$urandom, $urandom});
            b1.in_xor_en = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (b1.in_valid && b1.in_ready) begin
                q1.push_back(ref_exp(b1.in_data, b1.in_key, b1.in_xor_en));
                sent++;
            end
        end
        @(posedge clk); #1;
        b1.in_valid = 1'b0;
    endtask

    initial begin
        n_chk = 0; n_fail = 0; acc2 = 0; rnd_done = 1'b0;
        rst_n = 1'b0;
        b2.flush = 1'b0; b2.in_valid = 1'b0; b2.in_data = '0; b2.in_key = '0; b2.in_xor_en = 1'b0; b2.out_ready = 1'b1;
        b1.flush = 1'b0; b1.in_valid = 1'b0; b1.in_data = '0; b1.in_key = '0; b1.in_xor_en = 1'b0; b1.out_ready = 1'b1;

        // Reset state and ready release timing
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid2", 64'(b2.out_valid), 64'd0);
        chk("rst_out_data2", 64'(b2.out_data), 64'd0);
        chk("rst_in_ready2", 64'(b2.in_ready), 64'd0);
        chk("rst_out_valid1", 64'(b1.out_valid), 64'd0);
        chk("rst_in_ready1", 64'(b1.in_ready), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_before_edge", 64'(b2.in_ready), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("ready_after_edge2", 64'(b2.in_ready), 64'd1);
        chk("ready_after_edge1", 64'(b1.in_ready), 64'd1);

        fork
            mon2();
            mon1();
        join_none

        // 1: DES E(R)^K with two-cycle latency
        @(posedge clk); #1;
        send2(32'hF0AAF0AA, 48'h1B02EFFC7072, 1'b1, 48'h6117BA866527);
        b2.in_valid = 1'b0;
        @(negedge clk);
        chk("t1_lat_early", 64'(b2.out_valid), 64'd0);
        @(negedge clk);
        chk("t1_lat_valid", 64'(b2.out_valid), 64'd1);
        drain("t1_drain");

        // 2: expansion only, key ignored
        send2(32'hF0AAF0AA, 48'h1B02EFFC7072, 1'b0, 48'h7A15557A1555);
        send2(32'h00000001, 48'hFFFFFFFFFFFF, 1'b0, 48'h800000000002);
        b2.in_valid = 1'b0;
        drain("t2_drain");

        // 3: backpressure for four edges; zero data makes each beat equal its key
        acc2 = 0;
        b2.out_ready = 1'b0;
        fork
            begin
                send2(32'h0, 48'h000000000011, 1'b1, 48'h000000000011);
                send2(32'h0, 48'h000000002200, 1'b1, 48'h000000002200);
                send2(32'h0, 48'h000000330000, 1'b1, 48'h000000330000);
                send2(32'h0, 48'h000044000000, 1'b1, 48'h000044000000);
                send2(32'h0, 48'h550000000000, 1'b1, 48'h550000000000);
                b2.in_valid = 1'b0;
            end
            begin
                repeat (2) @(posedge clk);
                @(negedge clk);
                chk("t3_full_ready", 64'(b2.in_ready), 64'd0);
                chk("t3_accepts_full", 64'(acc2), 64'd2);
                repeat (2) @(posedge clk);
                #1;
                b2.out_ready = 1'b1;
            end
        join
        drain("t3_drain");
        chk("t3_accepts_total", 64'(acc2), 64'd5);

        // 4: flush with two beats in flight and a new beat offered
        send2(32'hFFFFFFFF, 48'h0, 1'b0, 48'hFFFFFFFFFFFF);
        send2(32'h00000001, 48'h0, 1'b0, 48'h800000000002);
        b2.flush = 1'b1;
        b2.in_valid = 1'b1; b2.in_data = 32'h12345678; b2.in_key = '0; b2.in_xor_en = 1'b0;
        @(negedge clk);
        chk("t4_flush_ready", 64'(b2.in_ready), 64'd0);
        @(posedge clk); #1;
        b2.flush = 1'b0;
        b2.in_valid = 1'b0;
        q2.delete();
        @(negedge clk);
        chk("t4_flushed_valid", 64'(b2.out_valid), 64'd0);
        @(negedge clk);
        chk("t4_no_stale", 64'(b2.out_valid), 64'd0);
        @(posedge clk); #1;
        send2(32'h80000000, 48'h0, 1'b0, 48'h400000000001);
        b2.in_valid = 1'b0;
        drain("t4_drain");

        // 5: reset mid-stream
        send2(32'hFFFFFFFF, 48'h0F0F0F0F0F0F, 1'b1, 48'hF0F0F0F0F0F0);
        send2(32'h00000000, 48'h123456789ABC, 1'b1, 48'h123456789ABC);
        rst_n = 1'b0;
        b2.in_valid = 1'b0;
        q2.delete();
        #1;
        chk("t5_rst_valid", 64'(b2.out_valid), 64'd0);
        chk("t5_rst_data", 64'(b2.out_data), 64'd0);
        chk("t5_rst_ready", 64'(b2.in_ready), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("t5_ready_wait", 64'(b2.in_ready), 64'd0);
        chk("t5_no_partial", 64'(b2.out_valid), 64'd0);
        @(posedge clk); #1;
        send2(32'h00000001, 48'h000000000001, 1'b1, 48'h800000000003);
        b2.in_valid = 1'b0;
        @(negedge clk);
        chk("t5_lat_early", 64'(b2.out_valid), 64'd0);
        @(negedge clk);
        chk("t5_lat_valid", 64'(b2.out_valid), 64'd1);
        drain("t5_drain");

        // Single-stage instance: one-cycle latency
        b1.in_valid = 1'b1; b1.in_data = 32'hF0AAF0AA; b1.in_key = 48'h1B02EFFC7072; b1.in_xor_en = 1'b1;
        @(negedge clk);
        chk("s1_ready", 64'(b1.in_ready), 64'd1);
        if (b1.in_ready) q1.push_back(48'h6117BA866527);
        @(posedge clk); #1;
        b1.in_valid = 1'b0;
        @(negedge clk);
        chk("s1_lat_valid", 64'(b1.out_valid), 64'd1);
        drain("s1_drain");

        // 6: random valid/ready soak on both instances
        fork
            begin
                fork
                    rnd2();
                    rnd1();
                join
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    b2.out_ready = ($urandom_range(0, 3) != 0);
                end
                b2.out_ready = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    b1.out_ready = ($urandom_range(0, 3) != 0);
                end
                b1.out_ready = 1'b1;
            end
        join
        drain("rnd_drain");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
